// File: rtl/id_pkg.sv
// Shared types, ASCII constants and helpers for the identifier emitter.
// Used by id_emitter and the id_track recognizer model.
package id_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        LET,
        DIG,
        TRM
    } state_t;

    localparam logic [7:0] CH_A_UP = 8'h41;
    localparam logic [7:0] CH_Z_UP = 8'h5A;
    localparam logic [7:0] CH_A_LO = 8'h61;
    localparam logic [7:0] CH_Z_LO = 8'h7A;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= CH_A_UP) && (c <= CH_Z_UP)) ||
               ((c >= CH_A_LO) && (c <= CH_Z_LO));
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    // ceil(w*log10(2)) in fixed point
    function automatic int bcd_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/id_track.sv
// Letter+ digit+ recognizer model fed with every accepted byte.
// o_match is high while the bytes seen so far form a complete identifier.
module id_track
    import id_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic [7:0] i_char,
    output logic       o_match
);

    typedef enum logic [1:0] {
        T_START,
        T_LET,
        T_DIG
    } tstate_t;

    tstate_t r_state;
    tstate_t w_state_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= T_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_valid) begin
            unique case (r_state)
                T_START: w_state_nxt = is_letter(i_char) ? T_LET : T_START;
                T_LET: begin
                    if (is_letter(i_char)) begin
                        w_state_nxt = T_LET;
                    end else if (is_digit(i_char)) begin
                        w_state_nxt = T_DIG;
                    end else begin
                        w_state_nxt = T_START;
                    end
                end
                T_DIG:   w_state_nxt = is_digit(i_char) ? T_DIG : T_START;
                default: w_state_nxt = T_START;
            endcase
        end
    end

    assign o_match = (r_state == T_DIG);

endmodule

// File: rtl/id_emitter.sv
// Serializes letter+ digit+ TERM_CHAR identifiers over a valid/ready byte bus.
// Define ID_EMITTER_SELFCHECK_EN to check the stream with an id_track model.
module id_emitter
    import id_pkg::*;
#(
    parameter int         NUM_W     = 16,
    parameter logic [7:0] TERM_CHAR = 8'h20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [7:0]       i_first,
    input  logic [3:0]       i_letter_cnt,
    input  logic [NUM_W-1:0] i_num,
    output logic [7:0]       o_char,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_chk_fail
);

    localparam int ND = bcd_digits(NUM_W);
    localparam int BW = 4 * ND;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam int CW = $clog2(NUM_W + 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]       r_char;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [7:0]       r_let;
    logic [3:0]       r_left;
    logic [NUM_W-1:0] r_bin;
    logic [BW-1:0]    r_bcd;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;

    logic          w_xfer;
    logic          w_start_ok;
    logic          w_conv_done;
    logic [BW-1:0] w_adj;
    logic [IW-1:0] w_lead;
    logic [IW-1:0] w_sel;
    logic [3:0]    w_nib;
    logic [7:0]    w_dchar;
    logic [7:0]    w_let_nxt;

    assign w_xfer      = r_valid && i_ready;
    assign w_start_ok  = is_letter(i_first) && (i_letter_cnt != 4'd0);
    assign w_conv_done = (r_cnt == CW'(NUM_W));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (i_start && w_start_ok) w_state_nxt = CONV;
            CONV: if (w_conv_done) w_state_nxt = LET;
            LET:  if (w_xfer && (r_left == 4'd1)) w_state_nxt = DIG;
            DIG:  if (w_xfer && (r_idx == '0)) w_state_nxt = TRM;
            TRM:  if (w_xfer) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_adj  = r_bcd;
        w_lead = '0;
        for (int i = 0; i < ND; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_lead = IW'(i);
            end
        end
    end

    // LET hands over the digit at r_idx; DIG moves on to the next lower one
    assign w_sel = (r_state == DIG) ? (r_idx - 1'b1) : r_idx;

    always_comb begin
        w_nib = 4'd0;
        for (int i = 0; i < ND; i++) begin
            if (w_sel == IW'(i)) begin
                w_nib = r_bcd[4*i +: 4];
            end
        end
    end

    assign w_dchar = CH_0 + {4'd0, w_nib};

    always_comb begin
        w_let_nxt = r_let + 8'd1;
        if (r_let == CH_Z_LO) begin
            w_let_nxt = CH_A_LO;
        end else if (r_let == CH_Z_UP) begin
            w_let_nxt = CH_A_UP;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_char  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_let   <= 8'h00;
            r_left  <= 4'd0;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (w_start_ok) begin
                            r_busy <= 1'b1;
                            r_let  <= i_first;
                            r_left <= i_letter_cnt;
                            r_bin  <= i_num;
                            r_bcd  <= '0;
                            r_cnt  <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    if (w_conv_done) begin
                        r_idx   <= w_lead;
                        r_valid <= 1'b1;
                        r_char  <= r_let;
                    end else begin
                        r_bcd <= {w_adj[BW-2:0], r_bin[NUM_W-1]};
                        r_bin <= r_bin << 1;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LET: begin
                    if (w_xfer) begin
                        if (r_left == 4'd1) begin
                            r_char <= w_dchar;
                        end else begin
                            r_left <= r_left - 4'd1;
                            r_let  <= w_let_nxt;
                            r_char <= w_let_nxt;
                        end
                    end
                end
                DIG: begin
                    if (w_xfer) begin
                        if (r_idx == '0) begin
                            r_char <= TERM_CHAR;
                        end else begin
                            r_idx  <= r_idx - 1'b1;
                            r_char <= w_dchar;
                        end
                    end
                end
                TRM: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_char  = r_char;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_err   = r_err;

`ifdef ID_EMITTER_SELFCHECK_EN
    logic w_trk;
    logic r_chk_dig;
    logic r_chk_trm;
    logic r_chk_fail;

    id_track u_track (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (w_xfer),
        .i_char  (r_char),
        .o_match (w_trk)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chk_dig  <= 1'b0;
            r_chk_trm  <= 1'b0;
            r_chk_fail <= 1'b0;
        end else begin
            r_chk_dig <= w_xfer && (r_state == DIG) && (r_idx == '0);
            r_chk_trm <= w_xfer && (r_state == TRM);
            if ((r_chk_dig && !w_trk) || (r_chk_trm && w_trk)) begin
                r_chk_fail <= 1'b1;
            end
        end
    end

    assign o_chk_fail = r_chk_fail;
`else
    assign o_chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_id_emitter.sv
// Directed table-driven bench for id_emitter.
module tb_id_emitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  first;
    logic [3:0]  letter_cnt;
    logic [15:0] num;
    logic [7:0]  chr;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        chk_fail;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_emitter dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_first      (first),
        .i_letter_cnt (letter_cnt),
        .i_num        (num),
        .o_char       (chr),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_chk_fail   (chk_fail)
    );

    typedef struct {
        logic [7:0]  first;
        logic [3:0]  cnt;
        logic [15:0] num;
        string       exp;
        bit          tog;
    } vec_t;

    vec_t tv[6];

    function automatic vec_t mk(logic [7:0] f, logic [3:0] c,
                                logic [15:0] n, string e, bit t);
        vec_t v;
        v.first = f;
        v.cnt   = c;
        v.num   = n;
        v.exp   = e;
        v.tog   = t;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(vec_t v);
        int  cyc;
        int  k;
        int  p;
        int  n;
        int  err_seen;
        bit  rdy;
        bit  prev_hold;
        logic [7:0] prev_char;
        n = v.exp.len();
        @(negedge clk);
        start      = 1'b1;
        first      = v.first;
        letter_cnt = v.cnt;
        num        = v.num;
        ready      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("first_byte_latency", cyc, 32'd17);
        k = 0;
        cyc = 0;
        p = 0;
        err_seen = 0;
        prev_hold = 1'b0;
        prev_char = 8'h00;
        while (k < n && cyc < 200) begin
            if (prev_hold) begin
                chk("hold", {23'd0, valid, chr}, {23'd0, 1'b1, prev_char});
            end
            if (err) err_seen++;
            rdy   = v.tog ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
            ready = rdy;
            // start attempts while busy must be ignored
            start = v.tog && (p % 2 == 1) && (k < n - 1);
            first = 8'h41;
            if (valid && rdy) begin
                chk($sformatf("byte%0d", k), {24'd0, chr}, {24'd0, v.exp[k]});
                k++;
            end
            prev_hold = valid && !rdy;
            prev_char = chr;
            p++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
        chk("all_bytes_seen", k, n);
        if (!v.tog) chk("no_bubbles", cyc, n);
        chk("no_err_while_busy", err_seen, 32'd0);
        chk("done_pulse", {30'd0, done, busy}, {30'd0, 1'b1, 1'b0});
        chk("valid_low_after", {31'd0, valid}, 32'd0);
        @(negedge clk);
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("chk_fail", {31'd0, chk_fail}, 32'd0);
    endtask

    task automatic bad_start(logic [7:0] f, logic [3:0] c, string nm);
        @(negedge clk);
        start      = 1'b1;
        first      = f;
        letter_cnt = c;
        num        = 16'd5;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_err"}, {29'd0, err, valid, busy}, {29'd0, 3'b100});
        @(negedge clk);
        chk({nm, "_idle"}, {29'd0, err, valid, busy}, {29'd0, 3'b000});
    endtask

    initial begin
        int cyc;
        tv[0] = mk(8'h79, 4'd3, 16'd407,   "yza407 ",   1'b0);
        tv[1] = mk(8'h51, 4'd1, 16'd0,     "Q0 ",       1'b0);
        tv[2] = mk(8'h5A, 4'd2, 16'd65535, "ZA65535 ",  1'b0);
        tv[3] = mk(8'h58, 4'd5, 16'd12,    "XYZAB12 ",  1'b1);
        tv[4] = mk(8'h6D, 4'd4, 16'd1000,  "mnop1000 ", 1'b0);
        tv[5] = mk(8'h58, 4'd5, 16'd12,    "XYZAB12 ",  1'b0);

        reset      = 1'b1;
        start      = 1'b0;
        first      = 8'h41;
        letter_cnt = 4'd1;
        num        = 16'd0;
        ready      = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_state", {18'd0, chr, valid, busy, done, err, chk_fail, 1'b0},
            32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(tv[i]);
        end

        bad_start(8'h35, 4'd3, "bad_first");
        bad_start(8'h42, 4'd0, "zero_cnt");

        // reset in the middle of the digit phase
        @(negedge clk);
        start      = 1'b1;
        first      = 8'h6B;
        letter_cnt = 4'd2;
        num        = 16'd4321;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        chk("mid_dig_char", {24'd0, chr}, 32'h34);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid_dig", {30'd0, valid, busy}, 32'd0);
        @(negedge clk);
        chk("reset_no_done", {31'd0, done}, 32'd0);
        run_vec(mk(8'h6B, 4'd2, 16'd4321, "kl4321 ", 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
